// File: rtl/multicycle_ctrl_if.sv
// Control bundle between the multicycle controller (master) and the datapath (slave).
// The datapath returns the instruction register contents and the ALU zero flag.
interface multicycle_ctrl_if;
  logic [31:0] instr;
  logic        zero;
  logic        pc_we;
  logic [1:0]  pc_src;
  logic        ir_we;
  logic        mem_we;
  logic        mem_addr_sel;
  logic        reg_we;
  logic [1:0]  reg_dst;
  logic [1:0]  wb_sel;
  logic [1:0]  alu_src_b;
  logic [2:0]  alu_ctrl;
  logic [2:0]  state;
  logic        illegal;

  modport master (
    input  instr, zero,
    output pc_we, pc_src, ir_we, mem_we, mem_addr_sel, reg_we,
           reg_dst, wb_sel, alu_src_b, alu_ctrl, state, illegal
  );

  modport slave (
    output instr, zero,
    input  pc_we, pc_src, ir_we, mem_we, mem_addr_sel, reg_we,
           reg_dst, wb_sel, alu_src_b, alu_ctrl, state, illegal
  );
endinterface

// File: rtl/multicycle_ctrl.sv
// Multicycle FETCH/DECODE/EXEC/MEM/WB controller for the single-memory MIPS-subset datapath.
// Optional feature: define BEQ_EN to decode opcode 0x04 as BEQ (otherwise it traps as illegal).
module multicycle_ctrl #(
  parameter int         MEM_LAT = 1,
  parameter logic [2:0] ALU_ADD = 3'd0,
  parameter logic [2:0] ALU_SUB = 3'd1,
  parameter logic [2:0] ALU_XOR = 3'd2,
  parameter logic [2:0] ALU_SLT = 3'd3
) (
  input logic               clk,
  input logic               reset_n,
  multicycle_ctrl_if.master bus
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd5
  } state_t;

  typedef enum logic [3:0] {
    CL_NONE, CL_LW, CL_SW, CL_J, CL_JAL, CL_JR, CL_BNE, CL_BEQ,
    CL_XORI, CL_ADDI, CL_ADD, CL_SUB, CL_SLT, CL_ILL
  } class_t;

  localparam logic [3:0] LAST_CNT = 4'(MEM_LAT - 1);

  state_t     state_q, state_d;
  class_t     class_q, class_d;
  logic [3:0] cnt_q, cnt_d;
  logic       illegal_q, illegal_d;

  class_t     decClass;
  logic       lastCnt;
  logic       pcWe, irWe, memWe, memAddrSel, regWe;
  logic [1:0] pcSrc, regDst, wbSel, aluSrcB;
  logic [2:0] aluCtrl;
  logic       unusedInstrBits;

  assign unusedInstrBits = ^bus.instr[25:6];
  assign lastCnt = (cnt_q == LAST_CNT);

  always_comb begin
    decClass = CL_ILL;
    unique case (bus.instr[31:26])
      6'h23: decClass = CL_LW;
      6'h2B: decClass = CL_SW;
      6'h02: decClass = CL_J;
      6'h03: decClass = CL_JAL;
      6'h05: decClass = CL_BNE;
`ifdef BEQ_EN
      6'h04: decClass = CL_BEQ;
`endif
      6'h0E: decClass = CL_XORI;
      6'h08: decClass = CL_ADDI;
      6'h00: begin
        unique case (bus.instr[5:0])
          6'h20:   decClass = CL_ADD;
          6'h22:   decClass = CL_SUB;
          6'h2A:   decClass = CL_SLT;
          6'h08:   decClass = CL_JR;
          default: decClass = CL_ILL;
        endcase
      end
      default: decClass = CL_ILL;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_FETCH;
      class_q   <= CL_NONE;
      cnt_q     <= 4'd0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      class_q   <= class_d;
      cnt_q     <= cnt_d;
      illegal_q <= illegal_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    class_d    = class_q;
    cnt_d      = cnt_q;
    illegal_d  = illegal_q;
    pcWe       = 1'b0;
    pcSrc      = 2'b00;
    irWe       = 1'b0;
    memWe      = 1'b0;
    memAddrSel = 1'b0;
    regWe      = 1'b0;
    regDst     = 2'b00;
    wbSel      = 2'b00;
    aluSrcB    = 2'b00;
    aluCtrl    = ALU_ADD;

    case (state_q)
      S_FETCH: begin
        if (lastCnt) begin
          irWe    = 1'b1;
          pcWe    = 1'b1;
          cnt_d   = 4'd0;
          state_d = S_DECODE;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end

      // Jumps complete here; PC already holds PC+4 for the JAL link value.
      S_DECODE: begin
        class_d = decClass;
        state_d = S_EXEC;
        case (decClass)
          CL_J: begin
            pcWe    = 1'b1;
            pcSrc   = 2'b01;
            state_d = S_FETCH;
          end
          CL_JAL: begin
            pcWe    = 1'b1;
            pcSrc   = 2'b01;
            regWe   = 1'b1;
            regDst  = 2'b10;
            wbSel   = 2'b10;
            state_d = S_FETCH;
          end
          CL_JR: begin
            pcWe    = 1'b1;
            pcSrc   = 2'b10;
            state_d = S_FETCH;
          end
          CL_ILL: begin
            illegal_d = 1'b1;
            state_d   = S_TRAP;
          end
          default: state_d = S_EXEC;
        endcase
      end

      S_EXEC: begin
        state_d = S_WB;
        case (class_q)
          CL_LW, CL_SW: begin
            aluSrcB = 2'b01;
            aluCtrl = ALU_ADD;
            state_d = S_MEM;
          end
          CL_ADDI: begin
            aluSrcB = 2'b01;
            aluCtrl = ALU_ADD;
          end
          CL_XORI: begin
            aluSrcB = 2'b10;
            aluCtrl = ALU_XOR;
          end
          CL_ADD: aluCtrl = ALU_ADD;
          CL_SUB: aluCtrl = ALU_SUB;
          CL_SLT: aluCtrl = ALU_SLT;
          CL_BNE: begin
            aluCtrl = ALU_SUB;
            pcWe    = !bus.zero;
            pcSrc   = 2'b11;
            state_d = S_FETCH;
          end
`ifdef BEQ_EN
          CL_BEQ: begin
            aluCtrl = ALU_SUB;
            pcWe    = bus.zero;
            pcSrc   = 2'b11;
            state_d = S_FETCH;
          end
`endif
          default: state_d = S_FETCH;
        endcase
      end

      // Store pulses only once even when the memory needs several cycles.
      S_MEM: begin
        memAddrSel = 1'b1;
        memWe      = (class_q == CL_SW) && (cnt_q == 4'd0);
        if (lastCnt) begin
          cnt_d   = 4'd0;
          state_d = (class_q == CL_LW) ? S_WB : S_FETCH;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end

      S_WB: begin
        regWe   = 1'b1;
        state_d = S_FETCH;
        case (class_q)
          CL_LW: wbSel = 2'b01;
          CL_ADD, CL_SUB, CL_SLT: regDst = 2'b01;
          default: begin
            wbSel  = 2'b00;
            regDst = 2'b00;
          end
        endcase
      end

      S_TRAP: illegal_d = 1'b1;

      default: begin
        state_d = S_FETCH;
        cnt_d   = 4'd0;
      end
    endcase
  end

  // Enables are forced low while reset is held so an aborted access never writes.
  assign bus.pc_we        = pcWe  & reset_n;
  assign bus.ir_we        = irWe  & reset_n;
  assign bus.mem_we       = memWe & reset_n;
  assign bus.reg_we       = regWe & reset_n;
  assign bus.pc_src       = pcSrc;
  assign bus.mem_addr_sel = memAddrSel;
  assign bus.reg_dst      = regDst;
  assign bus.wb_sel       = wbSel;
  assign bus.alu_src_b    = aluSrcB;
  assign bus.alu_ctrl     = aluCtrl;
  assign bus.state        = state_q;
  assign bus.illegal      = illegal_q;

endmodule
